// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N-channel button debouncer with edge, long-press and auto-repeat pulses
module btn_debounce_multi #(
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = 1000,
  parameter int DEPTH        = 8,
  parameter int LONG_TICKS   = 50000,
  parameter int REPEAT_TICKS = 10000,
  parameter int REPEAT_EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_rise,
  output logic [N_BTN-1:0] o_fall,
  output logic [N_BTN-1:0] o_long,
  output logic [N_BTN-1:0] o_repeat
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_PRE   = RW'(REPEAT_TICKS - 1);

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] sync;
  logic [DEPTH-1:0] shift_q [N_BTN];
  logic [DEPTH-1:0] shift_d [N_BTN];
  logic [HW-1:0]    hold_q  [N_BTN];
  logic [RW-1:0]    rep_q   [N_BTN];
  logic [N_BTN-1:0] rep_act;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] rise_d;
  logic [N_BTN-1:0] fall_d;
  logic [N_BTN-1:0] long_d;
  logic [N_BTN-1:0] rep_d;

  assign tick = (tick_cnt == TICK_LAST);

  // Level is judged on the post-shift value so it moves in the same edge as the sample.
  always_comb begin
    level_d = '0;
    rise_d  = '0;
    fall_d  = '0;
    long_d  = '0;
    rep_d   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      shift_d[i] = shift_q[i];
      if (tick) begin
        shift_d[i] = {sync[i], shift_q[i][DEPTH-1:1]};
      end
      if (&shift_d[i]) begin
        level_d[i] = 1'b1;
      end else if (~|shift_d[i]) begin
        level_d[i] = 1'b0;
      end else begin
        level_d[i] = o_level[i];
      end
      rise_d[i] = level_d[i] & ~o_level[i];
      fall_d[i] = ~level_d[i] & o_level[i];
      long_d[i] = o_level[i] & level_d[i] & tick & (hold_q[i] == HOLD_PRE);
      rep_d[i]  = rep_act[i] & level_d[i] & tick & (rep_q[i] == REP_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      sync_meta <= '0;
      sync      <= '0;
      rep_act   <= '0;
      o_level   <= '0;
      o_rise    <= '0;
      o_fall    <= '0;
      o_long    <= '0;
      o_repeat  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        shift_q[i] <= '0;
        hold_q[i]  <= '0;
        rep_q[i]   <= '0;
      end
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      sync_meta <= i_btn;
      sync      <= sync_meta;
      o_level   <= level_d;
      o_rise    <= rise_d;
      o_fall    <= fall_d;
      o_long    <= long_d;
      o_repeat  <= (REPEAT_EN != 0) ? (rise_d | long_d | rep_d) : '0;
      for (int i = 0; i < N_BTN; i++) begin
        shift_q[i] <= shift_d[i];
        // Releasing drops hold and repeat state in the same edge as the fall pulse.
        if (!level_d[i]) begin
          hold_q[i]  <= '0;
          rep_q[i]   <= '0;
          rep_act[i] <= 1'b0;
        end else begin
          if (o_level[i] && tick && (hold_q[i] != HOLD_MAX)) begin
            hold_q[i] <= hold_q[i] + HW'(1);
          end
          if (long_d[i]) begin
            rep_act[i] <= 1'b1;
            rep_q[i]   <= '0;
          end else if (rep_act[i] && tick) begin
            rep_q[i] <= rep_d[i] ? '0 : rep_q[i] + RW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - scoreboard bench for btn_debounce_multi
module tb_btn_debounce_multi;
  localparam int NB = 2;
  localparam int TD = 4;
  localparam int DP = 4;
  localparam int LT = 10;
  localparam int RT = 3;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_LONG = 2;
  localparam int K_REP  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] i_btn = '0;
  logic [NB-1:0] o_level, o_rise, o_fall, o_long, o_repeat;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;
  ev_t exp_q[$];

  btn_debounce_multi #(
    .N_BTN(NB), .TICK_DIV(TD), .DEPTH(DP),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .o_long(o_long), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic string kname(int k);
    case (k)
      K_RISE:  return "rise";
      K_FALL:  return "fall";
      K_LONG:  return "long";
      default: return "repeat";
    endcase
  endfunction

  // first tick cycle at or after x (ticks occur where cycle % TD == TD-1)
  function automatic int ft(int x);
    int t = x;
    while (t % TD != TD - 1) t++;
    return t;
  endfunction

  function automatic void push_ev(int c, int ch, int k);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = k;
    exp_q.push_back(e);
  endfunction

  // expected pulses for a press rising at r and ending (fall or cutoff) at f
  function automatic void push_press(int ch, int r, int f, bit with_fall);
    push_ev(r, ch, K_RISE);
    push_ev(r, ch, K_REP);
    if (r + LT * TD < f) begin
      push_ev(r + LT * TD, ch, K_LONG);
      for (int t = r + LT * TD; t < f; t += RT * TD) push_ev(t, ch, K_REP);
    end
    if (with_fall) push_ev(f, ch, K_FALL);
  endfunction

  function automatic int settle(int c);
    return ft(c + 2) + (DP - 1) * TD + 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < NB; ch++) begin
        logic [3:0] pv;
        int idx;
        pv = {o_repeat[ch], o_long[ch], o_fall[ch], o_rise[ch]};
        for (int k = 0; k < 4; k++) begin
          if (pv[k]) begin
            idx = -1;
            foreach (exp_q[j])
              if (idx < 0 && exp_q[j].cyc == cyc && exp_q[j].ch == ch && exp_q[j].kind == k) idx = j;
            checks++;
            if (idx < 0) begin
              errors++;
              $display("FAIL pulse_%s ch%0d cycle %0d: observed 1, expected 0", kname(k), ch, cyc);
            end else begin
              exp_q.delete(idx);
            end
          end
        end
      end
      for (int j = exp_q.size() - 1; j >= 0; j--) begin
        if (exp_q[j].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL pulse_%s ch%0d cycle %0d: observed 0, expected 1", kname(exp_q[j].kind), exp_q[j].ch, exp_q[j].cyc);
          exp_q.delete(j);
        end
      end
    end
  end

  task automatic wait_until(int n);
    for (int g = 0; g < 4000 && cyc < n; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_level, o_rise, o_fall, o_long, o_repeat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: observed %b, expected 0", {o_level, o_rise, o_fall, o_long, o_repeat});
    end
    rst_n = 1'b1;
    wait_until(100);
    checks++;
    if ({o_level, o_rise, o_fall, o_long, o_repeat} !== '0) begin
      errors++;
      $display("FAIL idle_outputs: observed %b, expected 0", {o_level, o_rise, o_fall, o_long, o_repeat});
    end
  endtask

  task automatic test_clean_press;
    for (int ph = 1; ph <= 2; ph++) begin
      int p, r, f, first;
      p = ((cyc / TD) + 1) * TD + ph;
      wait_until(p);
      r = settle(p);
      f = settle(r + 14);
      push_press(0, r, f, 1'b1);
      i_btn[0] = 1'b1;
      first = -1;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (first < 0 && o_level[0]) first = cyc;
      end
      checks++;
      if (first != r || first - p < 15 || first - p > 18) begin
        errors++;
        $display("FAIL rise_latency ph%0d: observed %0d, expected %0d", ph, first - p, r - p);
      end
      wait_until(r + 14);
      i_btn[0] = 1'b0;
      wait_until(f + 10);
      checks++;
      if (exp_q.size() != 0 || o_level[0] !== 1'b0) begin
        errors++;
        $display("FAIL clean_press_end ph%0d: observed pending %0d level %b, expected 0 0", ph, exp_q.size(), o_level[0]);
      end
    end
  endtask

  task automatic test_bounce;
    int c, r;
    logic [4:0] seq;
    seq = 5'b10101;
    c = ((cyc / TD) + 1) * TD;
    r = c + 8 * TD;
    push_press(0, r, settle(r + TD), 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_until(c + k * TD);
      i_btn[0] = seq[4 - k];
    end
    wait_until(r - 1);
    @(negedge clk);
    checks++;
    if (o_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level_before: observed %b, expected 0", o_level[0]);
    end
    @(negedge clk);
    checks++;
    if (o_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_level_after: observed %b, expected 1", o_level[0]);
    end
    wait_until(r + TD);
    i_btn[0] = 1'b0;
    wait_until(settle(r + TD) + 10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_pending: observed %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_long_repeat;
    int c, r, f;
    c = ((cyc / TD) + 1) * TD;
    r = settle(c);
    f = settle(r + 20 * TD);
    push_press(1, r, f, 1'b1);
    wait_until(c);
    i_btn[1] = 1'b1;
    wait_until(r + 20 * TD);
    i_btn[1] = 1'b0;
    wait_until(f + 20);
    checks++;
    if (exp_q.size() != 0 || o_level[1] !== 1'b0) begin
      errors++;
      $display("FAIL long_repeat_end: observed pending %0d level %b, expected 0 0", exp_q.size(), o_level[1]);
    end
  endtask

  task automatic test_simultaneous;
    int c, r;
    c = ((cyc / TD) + 1) * TD;
    r = settle(c);
    push_press(0, r, settle(r + 4), 1'b1);
    push_press(1, r, settle(r + 8), 1'b1);
    wait_until(c);
    i_btn = 2'b11;
    wait_until(r + 1);
    @(negedge clk);
    checks++;
    if (o_level !== 2'b11) begin
      errors++;
      $display("FAIL simul_level_both: observed %b, expected 11", o_level);
    end
    wait_until(r + 4);
    i_btn[0] = 1'b0;
    wait_until(r + 8);
    i_btn[1] = 1'b0;
    wait_until(r + 22);
    @(negedge clk);
    checks++;
    if (o_level !== 2'b10) begin
      errors++;
      $display("FAIL simul_level_indep: observed %b, expected 10", o_level);
    end
    wait_until(r + 40);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_pending: observed %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int c, r;
    c = ((cyc / TD) + 1) * TD;
    r = settle(c);
    push_press(0, r, r + LT * TD + 5, 1'b0);
    wait_until(c);
    i_btn[0] = 1'b1;
    wait_until(r + LT * TD + 5);
    checks++;
    if (exp_q.size() != 0 || o_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: observed pending %0d level %b, expected 0 1", exp_q.size(), o_level[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_level, o_rise, o_fall, o_long, o_repeat} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: observed %b, expected 0", {o_level, o_rise, o_fall, o_long, o_repeat});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = settle(0);
    push_press(0, r, settle(60), 1'b1);
    wait_until(60);
    i_btn[0] = 1'b0;
    wait_until(settle(60) + 20);
    checks++;
    if (exp_q.size() != 0 || o_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_end: observed pending %0d level %b, expected 0 0", exp_q.size(), o_level[0]);
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_long_repeat;
    test_simultaneous;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
